// File: rtl/xmpl_dsp_msf_pkg.sv
// Shared types and constants for the MSF request arbiter.
package xmpl_dsp_msf_pkg;

  localparam int OPND_W    = 12;
  localparam int RSLT_W    = 32;
  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } msf_state_e;

endpackage

// File: rtl/xmpl_dsp_rr_arb.sv
// Round-robin selector: the first requester after last_grant (wrapping) wins.
module xmpl_dsp_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int          ID_W = $clog2(NUM_REQ);
  localparam int unsigned NR   = NUM_REQ;

  // Scan from last_grant+1 around the ring; the first set request takes the grant.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 1; off <= NR; off++) begin
      idx = ID_W'((32'(last_grant) + off) % NR);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xmpl_dsp_msf_arb.sv
// Arbitrates NUM_REQ requesters onto a single MSF unit, one transaction in flight.
module xmpl_dsp_msf_arb
  import xmpl_dsp_msf_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*OPND_W-1:0]  req_operand_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
  output logic [RSLT_W-1:0]          rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       rsp_timeout_o,
  output logic                       msf_a_o,
  output logic [OPND_W-1:0]          msf_b_o,
  input  logic [RSLT_W-1:0]          msf_c_i,
  input  logic [31:0]                msf_status_i,
  output logic                       busy_o
);

  localparam int          ID_W  = $clog2(NUM_REQ);
  localparam int          CNT_W = $clog2(TIMEOUT_CYC);
  localparam int unsigned NR    = NUM_REQ;

  msf_state_e         state_q, state_d;
  logic [ID_W-1:0]    last_grant_q;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic [OPND_W-1:0]  grant_opnd;
  logic [OPND_W-1:0]  operand_q;
  logic [ID_W-1:0]    id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [RSLT_W-1:0]  data_q;
  logic               err_q;
  logic               tmo_q;
  logic               done;
  logic               timeout_hit;
  logic               unused_status;

  assign done          = msf_status_i[STAT_DONE];
  assign timeout_hit   = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign unused_status = ^msf_status_i[31:2];

  xmpl_dsp_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arb (
    .req        (req_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Encode the one-hot grant and pick the winning operand.
  always_comb begin
    grant_id   = '0;
    grant_opnd = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (grant[i]) begin
        grant_id   = ID_W'(i);
        grant_opnd = req_operand_i[i*OPND_W +: OPND_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next-state and per-state strobes; done beats timeout in the same cycle.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    msf_a_o     = 1'b0;
    msf_b_o     = '0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid_i) begin
          req_ready_o = grant;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        msf_a_o = 1'b1;
        msf_b_o = operand_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        msf_b_o = operand_q;
        if (done || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE);

  // Grant bookkeeping, wait counter and response capture.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      operand_q    <= '0;
      id_q         <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            last_grant_q <= grant_id;
            id_q         <= grant_id;
            operand_q    <= grant_opnd;
          end
        end
        ST_ISSUE: cnt_q <= '0;
        ST_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (done) begin
            data_q <= msf_c_i;
            err_q  <= msf_status_i[STAT_ERR];
            tmo_q  <= 1'b0;
          end else if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
            tmo_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_id_o      = id_q;
  assign rsp_data_o    = data_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;

endmodule

// File: tb/tb_xmpl_dsp_msf_arb.sv
// Randomized self-checking bench for xmpl_dsp_msf_arb with a transaction-level model.
module tb_xmpl_dsp_msf_arb;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 16;
  localparam int NEVER       = 1000;

  logic                   clk_i = 1'b0;
  logic                   reset_n_i;
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ*12-1:0]  req_operand_i;
  logic [NUM_REQ-1:0]     req_ready_o;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [1:0]             rsp_id_o;
  logic [31:0]            rsp_data_o;
  logic                   rsp_err_o;
  logic                   rsp_timeout_o;
  logic                   msf_a_o;
  logic [11:0]            msf_b_o;
  logic [31:0]            msf_c_i;
  logic [31:0]            msf_status_i;
  logic                   busy_o;

  int checks   = 0;
  int failures = 0;
  int last_grant_m;
  logic [11:0] ops [NUM_REQ];

  always #5 clk_i = ~clk_i;

  xmpl_dsp_msf_arb #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .req_valid_i   (req_valid_i),
    .req_operand_i (req_operand_i),
    .req_ready_o   (req_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_id_o      (rsp_id_o),
    .rsp_data_o    (rsp_data_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .msf_a_o       (msf_a_o),
    .msf_b_o       (msf_b_o),
    .msf_c_i       (msf_c_i),
    .msf_status_i  (msf_status_i),
    .busy_o        (busy_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Fair-share rule: list requesters in ring order after the last winner, take the first valid one.
  function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int last);
    int order[$];
    for (int k = 1; k <= NUM_REQ; k++) order.push_back((last + k) % NUM_REQ);
    foreach (order[j]) if (mask[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic logic [NUM_REQ-1:0] rand_mask();
    logic [NUM_REQ-1:0] m;
    do m = NUM_REQ'($urandom); while (m == '0);
    return m;
  endfunction

  task automatic rand_ops(input int fixed_op);
    for (int i = 0; i < NUM_REQ; i++) begin
      ops[i] = (fixed_op >= 0) ? 12'(fixed_op) : 12'($urandom);
      req_operand_i[i*12 +: 12] = ops[i];
    end
  endtask

  task automatic scramble();
    rand_ops(-1);
    req_valid_i  = NUM_REQ'($urandom);
    msf_status_i = $urandom;
    msf_c_i      = $urandom;
    rsp_ready_i  = 1'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready_o), 0);
    check_val({tag, "_rsp_valid"}, 32'(rsp_valid_o), 0);
    check_val({tag, "_rsp_id"},    32'(rsp_id_o), 0);
    check_val({tag, "_rsp_data"},  rsp_data_o, 0);
    check_val({tag, "_rsp_err"},   32'(rsp_err_o), 0);
    check_val({tag, "_rsp_tmo"},   32'(rsp_timeout_o), 0);
    check_val({tag, "_msf_a"},     32'(msf_a_o), 0);
    check_val({tag, "_msf_b"},     32'(msf_b_o), 0);
    check_val({tag, "_busy"},      32'(busy_o), 0);
  endtask

  task automatic do_reset();
    req_valid_i   = '0;
    req_operand_i = '0;
    rsp_ready_i   = 1'b0;
    msf_c_i       = '0;
    msf_status_i  = '0;
    reset_n_i     = 1'b0;
    #1;
    check_reset_outputs("rst");
    repeat (3) @(negedge clk_i);
    reset_n_i    = 1'b1;
    last_grant_m = NUM_REQ - 1;
  endtask

  // One full transaction starting in IDLE; done_at >= TIMEOUT_CYC means MSF never finishes.
  task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int done_at, input logic err_bit,
                         input logic [31:0] c_val, input int stall, input int fixed_op);
    int          g;
    logic [11:0] op;
    logic [31:0] exp_data;
    logic        exp_err, exp_tmo;
    scramble();
    rand_ops(fixed_op);
    req_valid_i = mask;
    g  = model_pick(mask, last_grant_m);
    op = ops[g];
    #1;
    check_val("grant", 32'(req_ready_o), 32'(1) << g);
    check_val("idle_busy", 32'(busy_o), 0);
    check_val("idle_msf_a", 32'(msf_a_o), 0);
    check_val("idle_msf_b", 32'(msf_b_o), 0);
    check_val("idle_rsp_valid", 32'(rsp_valid_o), 0);
    last_grant_m = g;
    @(negedge clk_i);
    scramble();
    #1;
    check_val("issue_msf_a", 32'(msf_a_o), 1);
    check_val("issue_msf_b", 32'(msf_b_o), 32'(op));
    check_val("issue_req_ready", 32'(req_ready_o), 0);
    check_val("issue_busy", 32'(busy_o), 1);
    @(negedge clk_i);
    exp_data = '0;
    exp_err  = 1'b1;
    exp_tmo  = 1'b1;
    for (int k = 0; k < TIMEOUT_CYC; k++) begin
      scramble();
      msf_status_i[0] = (k == done_at);
      if (k == done_at) begin
        msf_status_i[1] = err_bit;
        msf_c_i  = c_val;
        exp_data = c_val;
        exp_err  = err_bit;
        exp_tmo  = 1'b0;
      end
      #1;
      check_val("wait_msf_a", 32'(msf_a_o), 0);
      check_val("wait_msf_b", 32'(msf_b_o), 32'(op));
      check_val("wait_rsp_valid", 32'(rsp_valid_o), 0);
      check_val("wait_req_ready", 32'(req_ready_o), 0);
      @(negedge clk_i);
      if (k == done_at) break;
    end
    for (int s = 0; s <= stall; s++) begin
      scramble();
      req_valid_i = rand_mask();
      rsp_ready_i = (s == stall);
      #1;
      check_val("rsp_valid", 32'(rsp_valid_o), 1);
      check_val("rsp_id", 32'(rsp_id_o), 32'(g));
      check_val("rsp_data", rsp_data_o, exp_data);
      check_val("rsp_err", 32'(rsp_err_o), 32'(exp_err));
      check_val("rsp_tmo", 32'(rsp_timeout_o), 32'(exp_tmo));
      check_val("rsp_req_ready", 32'(req_ready_o), 0);
      check_val("rsp_msf_a", 32'(msf_a_o), 0);
      check_val("rsp_msf_b", 32'(msf_b_o), 0);
      @(negedge clk_i);
    end
    rsp_ready_i = 1'b0;
  endtask

  // Start a transaction, then pull reset while it is waiting on the MSF.
  task automatic abort_in_wait(input logic [NUM_REQ-1:0] mask, input int wait_k);
    int g;
    rand_ops(-1);
    req_valid_i  = mask;
    msf_status_i = '0;
    rsp_ready_i  = 1'b0;
    g = model_pick(mask, last_grant_m);
    #1;
    check_val("abort_grant", 32'(req_ready_o), 32'(1) << g);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    check_val("abort_msf_a", 32'(msf_a_o), 1);
    @(negedge clk_i);
    for (int k = 0; k < wait_k; k++) begin
      msf_status_i = 32'h2;
      #1;
      check_val("abort_wait_valid", 32'(rsp_valid_o), 0);
      @(negedge clk_i);
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    check_reset_outputs("abort");
    last_grant_m = NUM_REQ - 1;
    msf_status_i = 32'h1;
    msf_c_i      = 32'hDEAD_BEEF;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    do_reset();

    run_txn(4'b0001, 1, 1'b0, 32'h1234_5678, 0, 12'h0A5);

    do_reset();
    for (int t = 0; t < 8; t++) run_txn(4'b1111, $urandom_range(0, 5), 1'b0, $urandom, 0, -1);

    run_txn(rand_mask(), NEVER, 1'b0, $urandom, 0, -1);
    run_txn(rand_mask(), TIMEOUT_CYC - 1, 1'b1, $urandom, 0, -1);
    run_txn(4'b1111, 2, 1'b0, $urandom, 5, -1);
    run_txn(rand_mask(), 3, 1'b1, 32'hCAFE_0042, 1, -1);

    abort_in_wait(4'b0100, 3);
    run_txn(4'b0010, 1, 1'b0, $urandom, 0, -1);
    abort_in_wait(4'b1000, 0);
    run_txn(4'b1111, 0, 1'b0, $urandom, 0, -1);

    for (int t = 0; t < 40; t++) begin
      for (int gap = $urandom_range(0, 2); gap > 0; gap--) begin
        scramble();
        req_valid_i = '0;
        #1;
        check_val("gap_req_ready", 32'(req_ready_o), 0);
        check_val("gap_busy", 32'(busy_o), 0);
        @(negedge clk_i);
      end
      run_txn(rand_mask(), $urandom_range(0, TIMEOUT_CYC + 2), 1'($urandom), $urandom,
              $urandom_range(0, 3), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xmpl_dsp_msf_arb.md
XMPL_DSP_MSF_ARB -- requirements
Module: xmpl_dsp_msf_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one MSF unit (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 256, max cycles waiting for MSF done before abort (>=2).
REQ-003 SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port reset_n_i  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-006 SHALL have port req_operand_i  input  NUM_REQ x 12  per-requester operand.
REQ-007 SHALL have port req_ready_o  output  NUM_REQ  one-hot grant/accept strobe.
REQ-008 SHALL have port rsp_valid_o  output  1  response valid.
REQ-009 SHALL have port rsp_ready_i  input  1  response accepted by consumer.
REQ-010 SHALL have port rsp_id_o  output  clog2(NUM_REQ)  index of served requester.
REQ-011 SHALL have port rsp_data_o  output  32  captured MSF result.
REQ-012 SHALL have port rsp_err_o  output  1  MSF error or timeout.
REQ-013 SHALL have port rsp_timeout_o  output  1  response caused by timeout.
REQ-014 SHALL have port msf_a_o  output  1  MSF start pulse.
REQ-015 SHALL have port msf_b_o  output  12  MSF operand.
REQ-016 SHALL have port msf_c_i  input  32  MSF result.
REQ-017 SHALL have port msf_status_i  input  32  MSF status; bit0 done, bit1 error, others ignored.
REQ-018 SHALL have port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-019 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one transaction in flight.
REQ-020 IDLE: with any req_valid_i set, SHALL grant round-robin starting at last_grant+1 (wrapping at NUM_REQ-1 -> 0), pulse req_ready_o[g] for that cycle, latch operand and id, go ISSUE.
REQ-021 IDLE with no valid request SHALL stay IDLE with req_ready_o all zero.
REQ-022 ISSUE: msf_a_o SHALL be high for exactly one cycle; go WAIT; timeout counter cleared.
REQ-023 msf_b_o SHALL present the latched operand from ISSUE through end of WAIT, zero otherwise.
REQ-024 WAIT: msf_status_i[0]=1 SHALL capture msf_c_i into rsp_data_o, msf_status_i[1] into rsp_err_o, rsp_timeout_o=0, go RESP.
REQ-025 WAIT: counter reaching TIMEOUT_CYC-1 without done SHALL set rsp_data_o=0, rsp_err_o=1, rsp_timeout_o=1, go RESP.
REQ-026 Done and timeout in the same cycle: done SHALL win.
REQ-027 msf_status_i[0] outside WAIT SHALL be ignored.
REQ-028 RESP: rsp_valid_o high, rsp_id/data/err/timeout stable until rsp_ready_i; on handshake go IDLE.
REQ-029 Latency: accept at cycle T, msf_a_o at T+1, done sampled earliest T+2, rsp_valid_o earliest T+3.
REQ-030 No new grant SHALL occur before the RESP handshake completes; next grant earliest the cycle after it.
REQ-031 last_grant SHALL update only on grant; withdrawn requests before grant have no effect.

Reset
REQ-032 reset_n_i low SHALL asynchronously force IDLE, all outputs 0, counter 0, last_grant = NUM_REQ-1 (requester 0 wins first).
REQ-033 Reset mid-transaction SHALL abort silently: no response, msf_a_o not re-pulsed after release.

Structure
REQ-034 Package xmpl_dsp_msf_pkg SHALL hold state enum, operand/result widths (12/32), status bit indices (DONE=0, ERR=1).
REQ-035 Round-robin selection SHALL be sub-module xmpl_dsp_rr_arb (request vector + pointer in, one-hot grant out).

Verification
REQ-036 Single: req_valid_i=0001, operand 0x0A5, done with c=0x1234_5678 two cycles after start -> msf_b_o=0x0A5, one msf_a_o pulse, rsp id 0, data 0x12345678, err 0.
REQ-037 Fairness: all four valid continuously, 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-038 Timeout: TIMEOUT_CYC=16, done never asserted -> rsp_valid_o after 16 WAIT cycles, err 1, timeout 1, data 0.
REQ-039 Backpressure: rsp_ready_i low 5 cycles -> outputs stable, no new grant, req_ready_o 0 throughout.
REQ-040 Error: done with status=0x3 -> rsp_err_o 1, rsp_timeout_o 0, data = msf_c_i.
REQ-041 Reset in WAIT then release with req_valid_i=0010 -> no response for aborted request, requester 1 granted fresh.
